// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix vector streamer: FSM state encoding and
// the index-width helper used to size vec_idx.
package matrix_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // max(1, clog2(numVec)) so a single-vector matrix still has a 1-bit index
    function automatic int mvs_idx_width(input int numVec);
        return (numVec <= 2) ? 1 : $clog2(numVec);
    endfunction

endpackage

// File: rtl/mvs_shadow_buf.sv
// One-entry holding buffer for a matrix accepted while another one streams;
// only instantiated when MATRIX_VECTOR_STREAM_PREFETCH_EN is defined.
module mvs_shadow_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              desc_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic              desc_o
);

    logic              full_q;
    logic              full_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              desc_q;
    logic              desc_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        desc_d = desc_q;
        if (push_i) begin
            full_d = 1'b1;
            data_d = data_i;
            desc_d = desc_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            desc_q <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            desc_q <= desc_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign desc_o = desc_q;

endmodule

// File: rtl/matrix_vector_stream.sv
// Streams a loaded matrix out one vector per handshake, ascending or descending.
// Optional prefetch shadow buffer enabled by MATRIX_VECTOR_STREAM_PREFETCH_EN.
module matrix_vector_stream
    import matrix_pkg::*;
#(
    parameter int  NUM_VEC = 16,
    parameter int  VEC_W   = 256,
    localparam int IDX_W   = mvs_idx_width(NUM_VEC)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic signed [NUM_VEC*VEC_W-1:0]  matrix_in,
    input  logic                             load_desc,
    output logic signed [VEC_W-1:0]          vec_out,
    output logic                             vec_valid,
    input  logic                             vec_ready,
    output logic [IDX_W-1:0]                 vec_idx,
    output logic                             vec_last,
    output logic                             finish,
    output logic                             busy
);

    localparam int               MAT_W   = NUM_VEC * VEC_W;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_VEC - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [MAT_W-1:0] mat_q;
    logic [MAT_W-1:0] mat_d;
    logic             desc_q;
    logic             desc_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             valid_q;
    logic             valid_d;
    logic             finish_q;
    logic             finish_d;
    logic             armed_q;

    logic             loadFire;
    logic             vecFire;
    logic             lastFire;
    logic             isLast;
    logic             takeNew;
    logic [MAT_W-1:0] srcMat;
    logic             srcDesc;
    logic [VEC_W-1:0] vecSel;

    logic             shadowFull;
    logic [MAT_W-1:0] shadowMat;
    logic             shadowDesc;

    assign loadFire = load_valid & load_ready;
    assign vecFire  = valid_q & vec_ready;
    assign isLast   = desc_q ? (idx_q == '0) : (idx_q == IDX_MAX);
    assign lastFire = vecFire & isLast;

`ifdef MATRIX_VECTOR_STREAM_PREFETCH_EN
    logic shadowPush;
    logic shadowPop;

    // A load arriving mid-matrix parks in the shadow; at the final handshake it
    // bypasses the shadow and goes straight to the active buffer instead.
    assign shadowPush = loadFire & (state_q == ST_STREAM) & ~lastFire;
    assign shadowPop  = lastFire & shadowFull;

    mvs_shadow_buf #(
        .DATA_W (MAT_W)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .push_i (shadowPush),
        .pop_i  (shadowPop),
        .data_i (matrix_in),
        .desc_i (load_desc),
        .full_o (shadowFull),
        .data_o (shadowMat),
        .desc_o (shadowDesc)
    );

    assign load_ready = armed_q & ~shadowFull;
`else
    assign shadowFull = 1'b0;
    assign shadowMat  = '0;
    assign shadowDesc = 1'b0;
    assign load_ready = armed_q & (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d  = state_q;
        mat_d    = mat_q;
        desc_d   = desc_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        finish_d = lastFire;
        srcMat   = shadowFull ? shadowMat : matrix_in;
        srcDesc  = shadowFull ? shadowDesc : load_desc;
        takeNew  = 1'b0;

        if (state_q == ST_IDLE) begin
            takeNew = loadFire;
        end else if (lastFire) begin
            takeNew = shadowFull | loadFire;
        end

        if (takeNew) begin
            state_d = ST_STREAM;
            mat_d   = srcMat;
            desc_d  = srcDesc;
            idx_d   = srcDesc ? IDX_MAX : '0;
            valid_d = 1'b1;
        end else if (lastFire) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (vecFire) begin
            idx_d = desc_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
        end
    end

    // armed_q keeps load_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mat_q    <= '0;
            desc_q   <= 1'b0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mat_q    <= mat_d;
            desc_q   <= desc_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
            armed_q  <= 1'b1;
        end
    end

    // Vector k sits in the k-th slice counted from the MSB end
    always_comb begin
        vecSel = '0;
        for (int k = 0; k < NUM_VEC; k++) begin
            if (idx_q == IDX_W'(k)) begin
                vecSel = mat_q[(NUM_VEC-1-k)*VEC_W +: VEC_W];
            end
        end
    end

    assign vec_out   = vecSel;
    assign vec_valid = valid_q;
    assign vec_idx   = idx_q;
    assign vec_last  = valid_q & isLast;
    assign finish    = finish_q;
    assign busy      = (state_q == ST_STREAM) | shadowFull;

endmodule

// File: doc/matrix_vector_stream.md
MATRIX_VECTOR_STREAM -- requirements
Module: matrix_vector_stream

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 16, giving the number of vectors per matrix (legal range >= 1).
REQ-002 The block SHALL have parameter VEC_W, default 256, giving the bits per vector.
REQ-003 The block SHALL have derived constant IDX_W = max(1, clog2(NUM_VEC)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port load_valid, input, 1 bit: matrix_in and load_desc are valid.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block can accept a matrix.
REQ-008 The block SHALL have port matrix_in, input, signed NUM_VEC*VEC_W bits: flattened matrix, vector 0 in the MSB slice.
REQ-009 The block SHALL have port load_desc, input, 1 bit: order select, 0 = ascending, 1 = descending.
REQ-010 The block SHALL have port vec_out, output, signed VEC_W bits: the current vector.
REQ-011 The block SHALL have port vec_valid, output, 1 bit: vec_out, vec_idx and vec_last are valid.
REQ-012 The block SHALL have port vec_ready, input, 1 bit: the consumer accepts the vector.
REQ-013 The block SHALL have port vec_idx, output, IDX_W bits: matrix index of vec_out.
REQ-014 The block SHALL have port vec_last, output, 1 bit: vec_out is the final vector of the matrix.
REQ-015 The block SHALL have port finish, output, 1 bit: one-cycle pulse when a matrix has fully drained.
REQ-016 The block SHALL have port busy, output, 1 bit: a matrix is held or streaming.

Function
REQ-017 The block SHALL define vector k as matrix_in[(NUM_VEC-1-k)*VEC_W +: VEC_W].
REQ-018 The block SHALL accept a load on a cycle with load_valid & load_ready, capturing matrix_in and load_desc into the active buffer.
REQ-019 The block SHALL use FSM states IDLE and STREAM: IDLE->STREAM on load accept; STREAM->IDLE on the last-vector handshake when no further matrix is pending.
REQ-020 The block SHALL drive load_ready = 1 in IDLE and 0 in STREAM (non-prefetch build).
REQ-021 The block SHALL assert vec_valid the cycle after load accept, with vec_idx = 0 (ascending) or NUM_VEC-1 (descending).
REQ-022 The block SHALL hold vec_out, vec_idx and vec_last stable while vec_valid=1 and vec_ready=0; there is no timeout.
REQ-023 The block SHALL advance the index by +1 (ascending) or -1 (descending) on each vec_valid & vec_ready handshake, presenting the next vector the following cycle with no bubble.
REQ-024 The block SHALL assert vec_last with idx NUM_VEC-1 (ascending) or 0 (descending); NUM_VEC=1 makes the first vector also the last.
REQ-025 The block SHALL drop vec_valid on the cycle after the last handshake unless a pending matrix exists (REQ-031).
REQ-026 The block SHALL register finish, pulsing it for exactly one cycle after the last-vector handshake.
REQ-027 The block SHALL drive busy = 1 whenever the FSM is STREAM or the shadow buffer is full.
REQ-028 The block SHALL ignore load_valid while load_ready=0, leaving the held data unchanged.
REQ-029 The block SHALL not change the stream order mid-matrix because load_desc is sampled only at accept.

Reset
REQ-030 The block SHALL, while rst=0 and regardless of clock: enter IDLE, set vec_valid=0, vec_out=0, vec_idx=0, vec_last=0, finish=0, busy=0 and load_ready=0, and empty the shadow buffer. On the first edge after release, load_ready SHALL be 1. Reset during STREAM SHALL discard the matrix without a finish pulse.

Configuration
REQ-031 The block SHALL support macro MATRIX_VECTOR_STREAM_PREFETCH_EN. When defined, a one-entry shadow buffer is added and load_ready = !shadow_full, so a load is accepted in STREAM as well. On the last handshake with the shadow full, shadow moves to active and the first vector of the new matrix is valid the next cycle (zero bubble), finish still pulses, and the FSM stays in STREAM. A load accepted on the same cycle as the last handshake with the shadow empty goes directly to active, with the same behaviour. When the macro is undefined, there is no shadow and REQ-020 applies.

Structure
REQ-032 The block SHALL take the FSM state encoding (ST_IDLE, ST_STREAM) and the IDX_W helper function from shared package matrix_pkg.
REQ-033 The block SHALL place the shadow storage and the full flag in sub-module mvs_shadow_buf, instantiated only under the macro.

Verification
REQ-034 The bench SHALL load ascending with NUM_VEC=16, vector k = k, and vec_ready=1, expecting vec_idx 0..15 on consecutive cycles, vec_last at idx 15, and finish one cycle later.
REQ-035 The bench SHALL load descending, expecting the first vector idx 15, the last idx 0, and vec_last=1 with the idx-0 data.
REQ-036 The bench SHALL hold vec_ready=0 for 5 cycles at idx 3, expecting vec_out/idx to stay at 3 and idx 4 on the cycle after vec_ready returns to 1.
REQ-037 The bench SHALL pulse rst=0 mid-stream at idx 7, expecting vec_valid=0 immediately, no finish pulse, and load_ready=1 after release.
REQ-038 The bench SHALL, with the prefetch macro, load A then B during A, expecting A idx 15 followed by B idx 0 on the next cycle, two finish pulses, and load_ready=0 while the shadow is full.
REQ-039 The bench SHALL, with NUM_VEC=1, load and check that vec_last=1 on the first vector and that finish follows one cycle after the handshake.
